stopwatch_ctrl: RTL and testbench

- Control FSM for the stopwatch datapath.
- Takes synchronized button levels and turns each rising edge into a single-cycle internal strobe.
- Sequences IDLE/RUN/PAUSE, generates the count tick from a prescaler, and maintains the elapsed-time counter.
- Sits between the button synchronizers and the display/game-compare logic.

---
 rtl/stopwatch_ctrl.sv | 99 +++++++++
 tb/tb_stopwatch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge strobes, IDLE/RUN/PAUSE sequencing, tick prescaler, elapsed count.
// Optional macro STOPWATCH_CTRL_SATURATE_EN: count saturates at CNT_MAX and pauses instead of wrapping.
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 25000000,
  parameter int TICK_HZ = 100,
  parameter int CNT_MAX = 9999,
  localparam int CNT_W  = $clog2(CNT_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_stop_i,
  input  logic             clear_i,
  output logic             running_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] count_o,
  output logic             max_stb_o
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PS_W = $clog2(DIV);
  localparam logic [PS_W-1:0]  PS_TOP  = PS_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state, state_nx;
  logic [PS_W-1:0]  presc, presc_nx;
  logic [CNT_W-1:0] count_nx;
  logic             ss_prev, clr_prev;
  logic             ss_stb, clr_stb, at_max;

  // History flops reset high so a button held through reset yields no strobe.
  assign ss_stb    = start_stop_i & ~ss_prev;
  assign clr_stb   = clear_i & ~clr_prev;
  assign at_max    = (count_o == CNT_TOP);
  assign tick_o    = (state == RUN) && (presc == PS_TOP);
  assign max_stb_o = tick_o & at_max;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      presc     <= '0;
      count_o   <= '0;
      ss_prev   <= 1'b1;
      clr_prev  <= 1'b1;
      running_o <= 1'b0;
    end else begin
      state     <= state_nx;
      presc     <= presc_nx;
      count_o   <= count_nx;
      ss_prev   <= start_stop_i;
      clr_prev  <= clear_i;
      running_o <= (state_nx == RUN);
    end
  end

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    count_nx = count_o;
    if (clr_stb) begin
      // Clear dominates start/stop and any pending tick.
      state_nx = IDLE;
      presc_nx = '0;
      count_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          presc_nx = '0;
          if (ss_stb) state_nx = RUN;
        end
        RUN: begin
          if (ss_stb) state_nx = PAUSE;
          if (tick_o) begin
            presc_nx = '0;
            if (at_max) begin
`ifdef STOPWATCH_CTRL_SATURATE_EN
              count_nx = CNT_TOP;
              state_nx = PAUSE;
`else
              count_nx = '0;
`endif
            end else begin
              count_nx = count_o + 1'b1;
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
        end
        PAUSE: begin
          // Prescaler holds so the partial interval survives the pause.
          if (ss_stb) state_nx = RUN;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (DIV=4, CNT_MAX=5) against a cycle-level behavioural model.
module tb_stopwatch_ctrl;
  localparam int CLK_HZ  = 40;
  localparam int TICK_HZ = 10;
  localparam int CNT_MAX = 5;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef STOPWATCH_CTRL_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic             clk = 1'b0;
  logic             rst_n, ss, clr;
  logic             running, tick, max_stb;
  logic [CNT_W-1:0] count;

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .CNT_MAX(CNT_MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_stop_i(ss), .clear_i(clr),
    .running_o(running), .tick_o(tick), .count_o(count), .max_stb_o(max_stb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode, RUN cycles elapsed in current interval, elapsed count, last button levels.
  int m_mode, m_phase, m_cnt;
  bit m_ss_last, m_clr_last;
  bit exp_tick, exp_max, pre_tick, pre_max;
  logic [CNT_W+2:0] act_v, exp_v;

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_cnt = 0;
    m_ss_last = 1'b1; m_clr_last = 1'b1;
  endtask

  // One clock: drive levels, sample combinational outputs, advance model, sample registers.
  task automatic cycle(input bit s, input bit c);
    bit ss_rise, clr_rise;
    ss = s; clr = c;
    #1;
    exp_tick = (m_mode == M_RUN) && (m_phase == DIV - 1);
    exp_max  = exp_tick && (m_cnt == CNT_MAX);
    pre_tick = tick; pre_max = max_stb;
    @(posedge clk); #1;
    ss_rise  = s && !m_ss_last;
    clr_rise = c && !m_clr_last;
    m_ss_last = s; m_clr_last = c;
    if (clr_rise) begin
      m_mode = M_IDLE; m_cnt = 0; m_phase = 0;
    end else if (m_mode == M_RUN) begin
      if (ss_rise) m_mode = M_PAUSE;
      if (exp_tick) begin
        m_phase = 0;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        else if (SAT) m_mode = M_PAUSE;
        else m_cnt = 0;
      end else begin
        m_phase = (m_phase + 1) % DIV;
      end
    end else if (ss_rise) begin
      m_mode = M_RUN;
    end
    if (m_mode == M_IDLE) m_phase = 0;
    act_v = {running, count, pre_tick, pre_max};
    exp_v = {m_mode == M_RUN, CNT_W'(m_cnt), exp_tick, exp_max};
  endtask

  task automatic test_reset();
    int guard;
    ss = 1'b0; clr = 1'b0; rst_n = 1'b0;
    model_reset();
    #3;
    n_tests++;
    if ({running, count, tick, max_stb} !== '0) begin
      n_fail++; $display("FAIL reset_state act=%b req=0", {running, count, tick, max_stb});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    guard = 0;
    while (m_cnt < 3 && guard < 40) begin
      cycle(1'b0, 1'b0); guard++;
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL reset_prerun act=%b req=%b", act_v, exp_v); end
    end
    n_tests++;
    if (count !== 3'd3) begin n_fail++; $display("FAIL reset_reach3 act=%0d req=3", count); end
    ss = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({running, count, tick} !== '0) begin
      n_fail++; $display("FAIL reset_async act=%b req=0", {running, count, tick});
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0);
      n_tests++;
      if (act_v !== exp_v || running !== 1'b0) begin
        n_fail++; $display("FAIL reset_held act=%b req=%b", act_v, exp_v);
      end
    end
  endtask

  task automatic test_start();
    int tick_at;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    n_tests++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL start_running act=%b req=1", running); end
    tick_at = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b0);
      if (pre_tick && tick_at == 0) tick_at = i;
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL start_cyc%0d act=%b req=%b", i, act_v, exp_v); end
      if (i == 4) begin
        n_tests++;
        if (count !== 3'd1) begin n_fail++; $display("FAIL start_count1 act=%0d req=1", count); end
      end
    end
    n_tests++;
    if (tick_at != 4) begin n_fail++; $display("FAIL start_tick_pos act=%0d req=4", tick_at); end
    n_tests++;
    if (count !== 3'd2) begin n_fail++; $display("FAIL start_count2 act=%0d req=2", count); end
  endtask

  task automatic test_pause_resume();
    int tick_at;
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    n_tests++;
    if (running !== 1'b0 || count !== 3'd2) begin
      n_fail++; $display("FAIL pause_enter act=%b/%0d req=0/2", running, count);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0);
      n_tests++;
      if (act_v !== exp_v || count !== 3'd2) begin
        n_fail++; $display("FAIL pause_hold act=%b req=%b", act_v, exp_v);
      end
    end
    cycle(1'b1, 1'b0);
    tick_at = 0;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 1'b0);
      if (pre_tick && tick_at == 0) tick_at = i;
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL resume_cyc%0d act=%b req=%b", i, act_v, exp_v); end
    end
    n_tests++;
    if (tick_at != 2) begin n_fail++; $display("FAIL resume_tick_pos act=%0d req=2", tick_at); end
  endtask

  task automatic test_held();
    int rises;
    bit last;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    last = running; rises = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0);
      if (running && !last) rises++;
      last = running;
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL held_cyc%0d act=%b req=%b", i, act_v, exp_v); end
    end
    n_tests++;
    if (rises != 1 || running !== 1'b1) begin
      n_fail++; $display("FAIL held_single act=%0d/%b req=1/1", rises, running);
    end
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      cycle(1'b0, 1'b0);
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL wrap_cyc%0d act=%b req=%b", i, act_v, exp_v); end
      seen = pre_max;
    end
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL wrap_timeout act=0 req=max_stb"); end
    n_tests++;
    if (SAT ? (count !== 3'd5 || running !== 1'b0) : (count !== 3'd0 || running !== 1'b1)) begin
      n_fail++; $display("FAIL wrap_after act=%0d/%b req=%0d/%b", count, running, SAT ? 5 : 0, !SAT);
    end
    cycle(1'b0, 1'b0);
    n_tests++;
    if (act_v !== exp_v || pre_max !== 1'b0) begin
      n_fail++; $display("FAIL wrap_one_cycle act=%b req=%b", act_v, exp_v);
    end
  endtask

  task automatic test_simultaneous();
    int guard;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    guard = 0;
    while (!(m_mode == M_RUN && m_cnt == 4 && m_phase == DIV - 1) && guard < 60) begin
      cycle(1'b0, 1'b0); guard++;
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL simul_pre act=%b req=%b", act_v, exp_v); end
    end
    n_tests++;
    if (guard >= 60) begin n_fail++; $display("FAIL simul_timeout act=%0d req=<60", guard); end
    cycle(1'b1, 1'b1);
    n_tests++;
    if (pre_tick !== 1'b1 || count !== 3'd0 || running !== 1'b0) begin
      n_fail++; $display("FAIL simul_clear act=%b/%0d/%b req=1/0/0", pre_tick, count, running);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1);
      n_tests++;
      if (act_v !== exp_v || count !== 3'd0 || running !== 1'b0) begin
        n_fail++; $display("FAIL simul_idle act=%b req=%b", act_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    bit s, c;
    s = 1'b0; c = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      if ($urandom_range(0, 39) == 0) c = ~c;
      cycle(s, c);
      n_tests++;
      if (act_v !== exp_v) begin n_fail++; $display("FAIL random_cyc%0d act=%b req=%b", i, act_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_held();
    test_wrap();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
